// File: rtl/udp_ram_pkg.sv
// Shared types and helpers for the UDP payload to RAM write engine.
package udp_ram_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hF1;

   // Width of the per-field byte index; never narrower than one bit.
   function automatic int idx_width(input int addr_bytes, input int data_bytes);
      int m;
      m = (addr_bytes > data_bytes) ? addr_bytes : data_bytes;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/udp_ram_writer_be_shift_field.sv
// Byte-wide big-endian shift register: each loaded byte enters at the LSB,
// so after BYTES loads the first byte sits in the MSB position.
module be_shift_field #(
   parameter int BYTES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [7:0]         din,
   output logic [8*BYTES-1:0] q,
   output logic [8*BYTES-1:0] q_next
);

   // q_next lets the owner capture a completed field in the same cycle
   // that its final byte is shifted in.
   generate
      if (BYTES == 1) begin : g_one
         assign q_next = din;
      end else begin : g_many
         assign q_next = {q[8*BYTES-9:0], din};
      end
   endgenerate

   // Shift in one byte per enabled cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)       q <= '0;
      else if (load_en) q <= q_next;
   end

endmodule

// File: rtl/udp_ram_writer.sv
// Parses SYNC + {addr,data} records from a UDP payload stream and emits one
// RAM write strobe per complete record; reports clean or broken packet end.
module udp_ram_writer
   import udp_ram_pkg::*;
#(
   parameter int         ADDR_BYTES = 2,
   parameter int         DATA_BYTES = 3,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
   parameter int         LEN_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              udp_data,
   input  logic                    udp_vaild,
   input  logic [LEN_W-1:0]        udp_length,
   output logic                    wr_en,
   output logic [8*ADDR_BYTES-1:0] wr_addr,
   output logic [8*DATA_BYTES-1:0] wr_data,
   output logic [LEN_W-1:0]        rec_cnt,
   output logic                    pkt_done,
   output logic                    pkt_err
);

   localparam int IDX_W = idx_width(ADDR_BYTES, DATA_BYTES);
   localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [LEN_W-1:0]     left_q, left_d;
   logic                 last;
   logic                 addr_ld, data_ld, rec_full;
   logic                 wr_d, done_d, err_d, rec_clr;
   logic [8*ADDR_BYTES-1:0] addr_q, addr_next;
   logic [8*DATA_BYTES-1:0] data_q, data_next;

   be_shift_field #(.BYTES(ADDR_BYTES)) u_addr (
      .clk(clk), .rst_n(rst_n), .load_en(addr_ld), .din(udp_data),
      .q(addr_q), .q_next(addr_next)
   );

   be_shift_field #(.BYTES(DATA_BYTES)) u_data (
      .clk(clk), .rst_n(rst_n), .load_en(data_ld), .din(udp_data),
      .q(data_q), .q_next(data_next)
   );

   // left_q counts bytes still owed after the first; a later byte is the
   // final one when it consumes the last owed byte.
   assign last = (state_q == IDLE) ? (udp_length <= LEN_W'(1)) : (left_q <= LEN_W'(1));

   // Next-state, counters and pulse requests for the accepted byte.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      left_d   = left_q;
      addr_ld  = 1'b0;
      data_ld  = 1'b0;
      rec_full = 1'b0;
      wr_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rec_clr  = 1'b0;
      if (udp_vaild) begin
         if (state_q != IDLE && !last) left_d = left_q - 1'b1;
         case (state_q)
            IDLE: begin
               rec_clr = 1'b1;
               idx_d   = '0;
               left_d  = (udp_length == '0) ? '0 : udp_length - 1'b1;
               if (last) begin
                  done_d = (udp_data == SYNC_BYTE);
                  err_d  = (udp_data != SYNC_BYTE);
               end else begin
                  state_d = (udp_data == SYNC_BYTE) ? ADDR : DROP;
               end
            end
            ADDR: begin
               addr_ld = 1'b1;
               if (last) begin
                  done_d  = (idx_q == '0);
                  err_d   = (idx_q != '0);
                  idx_d   = '0;
                  state_d = IDLE;
               end else if (idx_q == ADDR_LAST) begin
                  idx_d   = '0;
                  state_d = DATA;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            DATA: begin
               data_ld  = 1'b1;
               rec_full = (idx_q == DATA_LAST);
               wr_d     = rec_full;
               if (last) begin
                  done_d  = rec_full;
                  err_d   = !rec_full;
                  idx_d   = '0;
                  state_d = IDLE;
               end else if (rec_full) begin
                  idx_d   = '0;
                  state_d = ADDR;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            DROP: begin
               if (last) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Parser state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         left_q  <= left_d;
      end
   end

   // Registered write port, record counter and packet-end pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rec_cnt  <= '0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
      end else begin
         wr_en    <= wr_d;
         pkt_done <= done_d;
         pkt_err  <= err_d;
         if (wr_d) begin
            wr_addr <= addr_q;
            wr_data <= data_next;
         end
         if (rec_clr)                   rec_cnt <= '0;
         else if (wr_d && rec_cnt != '1) rec_cnt <= rec_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_udp_ram_writer.sv
// Scenario bench for udp_ram_writer with an expected-event scoreboard.
module tb_udp_ram_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  udp_data;
   logic        udp_vaild;
   logic [15:0] udp_length;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [23:0] wr_data;
   logic [15:0] rec_cnt;
   logic        pkt_done;
   logic        pkt_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [23:0] d;
   } wexp_t;

   typedef struct {
      bit          done;
      logic [15:0] rec;
      bit          with_wr;
   } pexp_t;

   wexp_t wq[$];
   pexp_t pq[$];
   wexp_t we;
   pexp_t pe;

   always #5 clk = ~clk;

   udp_ram_writer dut (
      .clk(clk), .rst_n(rst_n), .udp_data(udp_data), .udp_vaild(udp_vaild),
      .udp_length(udp_length), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rec_cnt(rec_cnt), .pkt_done(pkt_done), .pkt_err(pkt_err)
   );

   // Scoreboard: every strobe or pulse must match the next expected event.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (pkt_done === 1'b1 && pkt_err === 1'b1) begin
            checks++; errors++;
            $display("FAIL pulse_excl: done=1 err=1, required at most one");
         end
         if (wr_en === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%h data=%h", wr_addr, wr_data);
            end else begin
               we = wq.pop_front();
               if (wr_addr !== we.a || wr_data !== we.d) begin
                  errors++;
                  $display("FAIL write: got %h/%h, required %h/%h", wr_addr, wr_data, we.a, we.d);
               end
            end
         end
         if (pkt_done === 1'b1 || pkt_err === 1'b1) begin
            checks++;
            if (pq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: done=%b err=%b", pkt_done, pkt_err);
            end else begin
               pe = pq.pop_front();
               if (pkt_done !== pe.done || pkt_err !== !pe.done || rec_cnt !== pe.rec ||
                   wr_en !== pe.with_wr) begin
                  errors++;
                  $display("FAIL pulse: got done=%b err=%b rec=%0d wr=%b, required done=%b rec=%0d wr=%b",
                           pkt_done, pkt_err, rec_cnt, wr_en, pe.done, pe.rec, pe.with_wr);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input logic [7:0] b[$], input int len, input int gap);
      for (int i = 0; i < b.size(); i++) begin
         udp_vaild  = 1'b1;
         udp_data   = b[i];
         udp_length = len[15:0];
         tick();
         if (gap > 0) begin
            udp_vaild = 1'b0;
            repeat (gap) tick();
         end
      end
      udp_vaild = 1'b0;
   endtask

   // Bounded wait for the scoreboard to drain, plus settling cycles.
   task automatic wait_idle();
      for (int n = 0; n < 60 && (wq.size() != 0 || pq.size() != 0); n++) tick();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; udp_vaild = 1'b0; udp_data = 8'h00; udp_length = 16'd0;
      repeat (3) tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, rec_cnt, pkt_done, pkt_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b a=%h d=%h rec=%0d done=%b err=%b, required all 0",
                  wr_en, wr_addr, wr_data, rec_cnt, pkt_done, pkt_err);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single(input int gap, input string name);
      logic [7:0] p[$];
      p = '{8'hF1, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
      wq.push_back('{a: 16'h0010, d: 24'hAABBCC});
      pq.push_back('{done: 1'b1, rec: 16'd1, with_wr: 1'b1});
      send_pkt(p, 6, gap);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d writes %0d pulses left, required 0", name, wq.size(), pq.size());
      end
      checks++;
      if (rec_cnt !== 16'd1 || wr_addr !== 16'h0010 || wr_data !== 24'hAABBCC || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL %s_hold: rec=%0d a=%h d=%h en=%b, required 1/0010/aabbcc/0",
                  name, rec_cnt, wr_addr, wr_data, wr_en);
      end
      wq.delete(); pq.delete();
   endtask

   task automatic test_two_records();
      logic [7:0] p[$];
      p = '{8'hF1, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h12, 8'h35, 8'h04, 8'h05, 8'h06};
      wq.push_back('{a: 16'h1234, d: 24'h010203});
      wq.push_back('{a: 16'h1235, d: 24'h040506});
      pq.push_back('{done: 1'b1, rec: 16'd2, with_wr: 1'b1});
      send_pkt(p, 11, 0);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0 || rec_cnt !== 16'd2) begin
         errors++;
         $display("FAIL two_records: left %0d/%0d rec=%0d, required 0/0 rec=2", wq.size(), pq.size(), rec_cnt);
      end
      wq.delete(); pq.delete();
   endtask

   task automatic test_truncated();
      logic [7:0] p[$];
      p = '{8'hF1, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h00, 8'h02};
      wq.push_back('{a: 16'h0001, d: 24'h112233});
      pq.push_back('{done: 1'b0, rec: 16'd1, with_wr: 1'b0});
      send_pkt(p, 8, 0);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0 || wr_addr !== 16'h0001) begin
         errors++;
         $display("FAIL truncated: left %0d/%0d addr=%h, required 0/0 addr=0001", wq.size(), pq.size(), wr_addr);
      end
      wq.delete(); pq.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] p[$];
      logic [7:0] q[$];
      p = '{8'hF0, 8'hF1, 8'h00, 8'h05};
      q = '{8'hF1, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE};
      pq.push_back('{done: 1'b0, rec: 16'd0, with_wr: 1'b0});
      wq.push_back('{a: 16'h0005, d: 24'hDEADBE});
      pq.push_back('{done: 1'b1, rec: 16'd1, with_wr: 1'b1});
      send_pkt(p, 4, 0);
      send_pkt(q, 6, 0);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0) begin
         errors++;
         $display("FAIL back_to_back: left %0d/%0d, required 0/0", wq.size(), pq.size());
      end
      wq.delete(); pq.delete();
   endtask

   task automatic test_boundary();
      logic [7:0] p[$];
      // single-byte packets: length 1 and length 0 both mean just the sync
      p = '{8'hF1};
      pq.push_back('{done: 1'b1, rec: 16'd0, with_wr: 1'b0});
      send_pkt(p, 1, 0);
      pq.push_back('{done: 1'b1, rec: 16'd0, with_wr: 1'b0});
      send_pkt(p, 0, 0);
      p = '{8'h00};
      pq.push_back('{done: 1'b0, rec: 16'd0, with_wr: 1'b0});
      send_pkt(p, 1, 0);
      // trailing byte at a record boundary still ends cleanly
      p = '{8'hF1, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h55};
      wq.push_back('{a: 16'h0010, d: 24'hAABBCC});
      pq.push_back('{done: 1'b1, rec: 16'd1, with_wr: 1'b0});
      send_pkt(p, 7, 0);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0) begin
         errors++;
         $display("FAIL boundary: left %0d/%0d, required 0/0", wq.size(), pq.size());
      end
      wq.delete(); pq.delete();
   endtask

   task automatic test_mid_reset();
      logic [7:0] p[$];
      p = '{8'hF1, 8'h00, 8'h10};
      send_pkt(p, 6, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, rec_cnt, pkt_done, pkt_err} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: en=%b a=%h d=%h rec=%0d done=%b err=%b, required all 0",
                  wr_en, wr_addr, wr_data, rec_cnt, pkt_done, pkt_err);
      end
      p = '{8'hF1, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03};
      wq.push_back('{a: 16'h0020, d: 24'h010203});
      pq.push_back('{done: 1'b1, rec: 16'd1, with_wr: 1'b1});
      send_pkt(p, 6, 0);
      wait_idle();
      checks++;
      if (wq.size() != 0 || pq.size() != 0 || wr_data !== 24'h010203) begin
         errors++;
         $display("FAIL mid_reset_recover: left %0d/%0d data=%h, required 0/0 data=010203",
                  wq.size(), pq.size(), wr_data);
      end
      wq.delete(); pq.delete();
   endtask

   initial begin
      test_reset();
      test_single(0, "single");
      test_two_records();
      test_truncated();
      test_back_to_back();
      test_single(3, "gaps");
      test_boundary();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
